// File: rtl/bp_stall_counter_bank.sv
// Saturating stall-reason / instret / cycle counter bank fed by the profiler
// classification stream, read and cleared through a command port with a one-entry response buffer.
module bp_stall_counter_bank #(
  parameter int unsigned num_reasons_p   = 33,
  parameter int unsigned counter_width_p = 32,
  parameter int unsigned addr_width_p    = 6
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       freeze_i,
  input  logic                       sample_v_i,
  input  logic                       sample_instret_i,
  input  logic [5:0]                 sample_reason_i,
  input  logic                       cmd_v_i,
  output logic                       cmd_ready_o,
  input  logic                       cmd_op_i,
  input  logic [addr_width_p-1:0]    cmd_addr_i,
  output logic                       resp_v_o,
  input  logic                       resp_ready_i,
  output logic [counter_width_p-1:0] resp_data_o
);

  localparam int unsigned num_ctr_lp     = num_reasons_p + 2;
  localparam int unsigned instret_idx_lp = num_reasons_p;
  localparam int unsigned cycle_idx_lp   = num_reasons_p + 1;
  localparam int unsigned idx_w_lp       = $clog2(num_ctr_lp);
  localparam logic [counter_width_p-1:0] ctr_max_lp = {counter_width_p{1'b1}};
  localparam logic [counter_width_p-1:0] ctr_one_lp = {{(counter_width_p-1){1'b0}}, 1'b1};

  logic [counter_width_p-1:0] ctr_q [num_ctr_lp];
  logic [counter_width_p-1:0] ctr_d [num_ctr_lp];
  logic                       resp_v_q, resp_v_d;
  logic [counter_width_p-1:0] resp_data_q, resp_data_d;

  logic                       sample_en;
  logic                       cmd_fire;
  logic                       clear_fire;
  logic [idx_w_lp-1:0]        inc_idx;
  logic [counter_width_p-1:0] rd_data;

  assign sample_en   = sample_v_i & ~freeze_i;
  assign cmd_ready_o = ~resp_v_q | resp_ready_i;
  assign cmd_fire    = cmd_v_i & cmd_ready_o;
  assign clear_fire  = cmd_fire & cmd_op_i;

  // Out-of-range reason codes fold into reason 0 (unknown).
  always_comb begin
    inc_idx = '0;
    if (sample_instret_i) begin
      inc_idx = idx_w_lp'(instret_idx_lp);
    end else if (32'(sample_reason_i) < num_reasons_p) begin
      inc_idx = idx_w_lp'(sample_reason_i);
    end
  end

  // Counter next state: clear beats any same-edge sample; increments saturate.
  always_comb begin
    for (int unsigned i = 0; i < num_ctr_lp; i++) begin
      ctr_d[i] = ctr_q[i];
      if (clear_fire) begin
        ctr_d[i] = '0;
      end else if (sample_en && (i == cycle_idx_lp || 32'(inc_idx) == i)
                   && ctr_q[i] != ctr_max_lp) begin
        ctr_d[i] = ctr_q[i] + ctr_one_lp;
      end
    end
  end

  // Read mux on pre-edge values; unmapped addresses return 0.
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < num_ctr_lp; i++) begin
      if (32'(cmd_addr_i) == i) begin
        rd_data = ctr_q[i];
      end
    end
  end

  always_comb begin
    resp_v_d    = resp_v_q;
    resp_data_d = resp_data_q;
    if (cmd_fire) begin
      resp_v_d    = 1'b1;
      resp_data_d = cmd_op_i ? '0 : rd_data;
    end else if (resp_ready_i) begin
      resp_v_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int unsigned i = 0; i < num_ctr_lp; i++) begin
        ctr_q[i] <= '0;
      end
      resp_v_q    <= 1'b0;
      resp_data_q <= '0;
    end else begin
      for (int unsigned i = 0; i < num_ctr_lp; i++) begin
        ctr_q[i] <= ctr_d[i];
      end
      resp_v_q    <= resp_v_d;
      resp_data_q <= resp_data_d;
    end
  end

  assign resp_v_o    = resp_v_q;
  assign resp_data_o = resp_data_q;

endmodule
